scytale_encryption: RTL

// Byte-serial scytale (columnar transposition) encryptor; the inverse of scytale_decryption. Buffers plaintext

---
 rtl/scytale_encryption.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/scytale_encryption.sv
// scytale_encryption: byte-serial scytale (columnar transposition) encryptor.
// Buffers plaintext bytes until START_TOKEN, then streams key_N*key_M ciphertext
// bytes, one per cycle. Cells past the received length are emitted as PAD_CHAR.
// Ports: clk, rst_n (async, active low); data_i/valid_i plaintext in;
//        key_N (columns), key_M (rows); busy, data_o/valid_o ciphertext out.
module scytale_encryption #(
  parameter int              D_WIDTH       = 8,
  parameter int              KEY_WIDTH     = 8,
  parameter int              MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_TOKEN = 8'hFA,
  parameter logic [D_WIDTH-1:0] PAD_CHAR    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int PW = 2 * KEY_WIDTH;

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
  logic [CW-1:0]        wr_cnt;
  logic [KEY_WIDTH-1:0] n_q, m_q, row, col;
  logic [PW-1:0]        len_q, emit_cnt;

  logic                 token, store, key_ok, emit_more;
  logic [PW-1:0]        prod, k;
  logic [CW-1:0]        rd_idx;
  logic [D_WIDTH-1:0]   rd_dat;
  logic                 busy_nxt, valid_nxt;
  logic [D_WIDTH-1:0]   data_nxt;

  // Token is recognised on any valid byte, but only acted on in LOAD.
  assign token  = valid_i && (data_i == START_TOKEN);
  assign prod   = PW'(key_N) * PW'(key_M);
  assign key_ok = (wr_cnt != '0) && (key_N != '0) && (key_M != '0) &&
                  (prod <= PW'(MAX_NOF_CHARS));
  assign store  = (state == LOAD) && valid_i && !token &&
                  (wr_cnt < CW'(MAX_NOF_CHARS));

  // emit_cnt == len_q marks the trailing cycle that returns to LOAD.
  assign emit_more = (emit_cnt != len_q);

  // Read address: row-major cell of the current (row, col) position.
  assign k      = PW'(row) * PW'(n_q) + PW'(col);
  assign rd_idx = CW'(k);
  assign rd_dat = (k < PW'(wr_cnt)) ? mem[rd_idx] : PAD_CHAR;

  // State register plus datapath counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      wr_cnt   <= '0;
      n_q      <= '0;
      m_q      <= '0;
      len_q    <= '0;
      emit_cnt <= '0;
      row      <= '0;
      col      <= '0;
      busy     <= 1'b0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      valid_o <= valid_nxt;
      data_o  <= data_nxt;
      case (state)
        LOAD: begin
          if (token) begin
            n_q      <= key_N;
            m_q      <= key_M;
            len_q    <= prod;
            emit_cnt <= '0;
            row      <= '0;
            col      <= '0;
            if (!key_ok) wr_cnt <= '0;
          end else if (store) begin
            wr_cnt <= wr_cnt + CW'(1);
          end
        end
        EMIT: begin
          if (emit_more) begin
            emit_cnt <= emit_cnt + PW'(1);
            // Walk down a column, then step to the next column.
            if (row == m_q - KEY_WIDTH'(1)) begin
              row <= '0;
              col <= col + KEY_WIDTH'(1);
            end else begin
              row <= row + KEY_WIDTH'(1);
            end
          end else begin
            wr_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Plaintext storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_cnt] <= data_i;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (token && key_ok) state_nxt = EMIT;
      EMIT:    if (!emit_more)      state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_nxt  = 1'b0;
    valid_nxt = 1'b0;
    data_nxt  = '0;
    case (state)
      LOAD: busy_nxt = token && key_ok;
      EMIT: begin
        if (emit_more) begin
          busy_nxt  = 1'b1;
          valid_nxt = 1'b1;
          data_nxt  = rd_dat;
        end
      end
      default: ;
    endcase
  end

endmodule
